instr_decode_stage: RTL and testbench

- Registered, parametrised successor to the combinational instruction field splitter.
- Decodes RV32I base formats plus the two lock-memory custom opcodes into fully formed fields with sign-extended immediates, a format tag and an illegal flag.
- Buffers decoded entries in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so fetch and execute decouple in each core of the dual-core design.

---
 rtl/instr_decode_stage.sv | 174 +++++++++++++++++
 tb/tb_instr_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// Registered decode stage: splits RV32I and lock-memory instructions into
// fields and buffers the results in a small FIFO with valid/ready handshakes.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            is_lock,
  output logic            illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            is_lock;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_instr[6:0];
    dec.fmt     = FMT_NONE;
    dec.is_lock = (in_instr[6:0] == 7'b1111110) || (in_instr[6:0] == 7'b1111111);
    case (in_instr[6:0])
      7'b0110011: begin
        dec.fmt    = FMT_R;
        dec.funct3 = in_instr[14:12];
        dec.funct7 = in_instr[31:25];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
      end
      7'b0010011, 7'b1100111, 7'b0000011, 7'b1111110: begin
        dec.funct3 = in_instr[14:12];
        dec.rs1    = in_instr[19:15];
        dec.rd     = in_instr[11:7];
        // Shift-immediates reuse the OP-IMM opcode but carry shamt + funct7
        if (in_instr[6:0] == 7'b0010011 &&
            (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)) begin
          dec.fmt    = FMT_SHIFT;
          dec.funct7 = in_instr[31:25];
          dec.imm    = XLEN'(in_instr[24:20]);
        end else begin
          dec.fmt    = FMT_I;
          dec.imm    = XLEN'($signed(in_instr[31:20]));
        end
      end
      7'b0100011, 7'b1111111: begin
        dec.fmt    = FMT_S;
        dec.funct3 = in_instr[14:12];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.imm    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt    = FMT_B;
        dec.funct3 = in_instr[14:12];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.imm    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt    = FMT_U;
        dec.rd     = in_instr[11:7];
        dec.imm    = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt    = FMT_J;
        dec.rd     = in_instr[11:7];
        dec.imm    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                    in_instr[30:21], 1'b0}));
      end
      default: begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        dec.rd      = in_instr[11:7];
      end
    endcase
  end

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: every field is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head      = empty ? '0 : mem[rd_ptr];
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign opcode    = head.opcode;
  assign funct3    = head.funct3;
  assign funct7    = head.funct7;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign imm       = head.imm;
  assign fmt       = head.fmt;
  assign is_lock   = head.is_lock;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: hand-decoded instruction table,
// handshake model with a queue, flush and asynchronous reset checks.
module tb_instr_decode_stage;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        lock;
    logic        ill;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            is_lock;
  logic            illegal;

  int   n_cmp = 0;
  int   n_err = 0;
  logic gate_v;
  exp_t stim[$];
  exp_t model_q[$];
  logic [31:0] next_pc = 32'h100;

  instr_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .fmt(fmt),
    .is_lock(is_lock), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-decoded reference table
  function automatic exp_t mk(input int idx, input logic [31:0] pc);
    exp_t e;
    case (idx)
      0: e = {32'h002081B3, pc, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3,  32'h0,        3'd0, 1'b0, 1'b0};
      1: e = {32'hFFF00293, pc, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5,  32'hFFFFFFFF, 3'd1, 1'b0, 1'b0};
      2: e = {32'hFE208EE3, pc, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0,  32'hFFFFFFFC, 3'd3, 1'b0, 1'b0};
      3: e = {32'h40325213, pc, 7'h13, 3'd5, 7'h20, 5'd4, 5'd0, 5'd4,  32'h3,        3'd6, 1'b0, 1'b0};
      4: e = {32'h00000000, pc, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0,  32'h0,        3'd7, 1'b0, 1'b1};
      5: e = {32'h0000A07F, pc, 7'h7F, 3'd2, 7'h00, 5'd1, 5'd0, 5'd0,  32'h0,        3'd2, 1'b1, 1'b0};
      6: e = {32'h123450B7, pc, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  32'h12345000, 3'd4, 1'b0, 1'b0};
      7: e = {32'hFF9FF0EF, pc, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1,  32'hFFFFFFF8, 3'd5, 1'b0, 1'b0};
      8: e = {32'h004120FE, pc, 7'h7E, 3'd2, 7'h00, 5'd2, 5'd0, 5'd1,  32'h4,        3'd1, 1'b1, 1'b0};
      default:
         e = {32'h1234FF8B, pc, 7'h0B, 3'd0, 7'h00, 5'd0, 5'd0, 5'd31, 32'h0,        3'd7, 1'b0, 1'b1};
    endcase
    return e;
  endfunction

  task automatic add_stim(input int idx);
    stim.push_back(mk(idx, next_pc));
    next_pc += 32'd4;
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {out_pc, opcode, funct3, funct7, rs1, rs2, rd, imm, fmt, is_lock, illegal}, '0);
  endtask

  task automatic compare_head(input exp_t e);
    check("out_pc",  out_pc,  e.pc);
    check("opcode",  opcode,  e.op);
    check("funct3",  funct3,  e.f3);
    check("funct7",  funct7,  e.f7);
    check("rs1",     rs1,     e.rs1);
    check("rs2",     rs2,     e.rs2);
    check("rd",      rd,      e.rd);
    check("imm",     imm,     e.imm);
    check("fmt",     fmt,     e.fmt);
    check("is_lock", is_lock, e.lock);
    check("illegal", illegal, e.ill);
  endtask

  // One clock: drive, check against the model, advance the model, step the clock
  task automatic cycle();
    int unsigned sz;
    exp_t e;
    in_valid = gate_v && (stim.size() != 0);
    if (stim.size() != 0) begin
      in_instr = stim[0].instr;
      in_pc    = stim[0].pc;
    end
    sz = model_q.size();
    check("in_ready",  in_ready,  sz < DEPTH);
    check("out_valid", out_valid, sz != 0);
    if (sz == 0) check_idle_outputs("empty_zero");
    if (flush) begin
      model_q.delete();
      if (in_valid) void'(stim.pop_front());
    end else begin
      if (sz != 0 && out_ready) begin
        e = model_q.pop_front();
        compare_head(e);
      end
      if (in_valid && sz < DEPTH) model_q.push_back(stim.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    gate_v    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < budget && (stim.size() != 0 || model_q.size() != 0); i++) cycle();
    check("drain_timeout", stim.size() + model_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    gate_v    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check_idle_outputs("rst_zero");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Every table format, streamed with the consumer always ready
    for (int i = 0; i < 10; i++) add_stim(i);
    drain(60);

    // Back-pressure: third word must wait for a pop
    gate_v    = 1'b1;
    out_ready = 1'b0;
    add_stim(1); add_stim(2); add_stim(3);
    repeat (4) cycle();
    drain(20);

    // Back-to-back stream for pointer wrap
    for (int i = 0; i < 12; i++) add_stim(i % 10);
    drain(40);

    // Random valid/ready pattern
    for (int i = 0; i < 60; i++) begin
      if (stim.size() < 2) add_stim($urandom_range(0, 9));
      gate_v    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(40);

    // Flush with a same-cycle push
    gate_v    = 1'b1;
    out_ready = 1'b0;
    add_stim(0); add_stim(6);
    repeat (2) cycle();
    add_stim(7);
    flush = 1'b1;
    cycle();
    flush  = 1'b0;
    gate_v = 1'b0;
    cycle();
    add_stim(5);
    drain(20);

    // Asynchronous reset between edges with two entries held
    gate_v    = 1'b1;
    out_ready = 1'b0;
    add_stim(3); add_stim(8);
    repeat (2) cycle();
    gate_v   = 1'b0;
    in_valid = 1'b0;
    check("pre_rst_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready",  in_ready,  1'b1);
    check_idle_outputs("async_rst_zero");
    model_q.delete();
    stim.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    add_stim(2);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
